mux8_scan_ctrl: RTL and testbench

Sequencer for the 8:1 single-bit input multiplexer (active-low enable, 3-bit address). On a start pulse it walks the masked-in channels in ascending order. For each channel it drives the mux address and enable, waits a settle interval, then samples the mux output. It returns all eight sampled bits as one byte with a done pulse. It sits between the mux and any consumer needing a parallel snapshot of the 8 mux inputs.

---
 rtl/mux_ctrl_pkg.sv | 12 +
 rtl/mux8_scan_ctrl_if.sv | 23 ++
 rtl/mux_next_ch.sv | 21 ++
 rtl/mux8_scan_ctrl.sv | 100 ++++++++++
 tb/tb_mux8_scan_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the 8:1 mux scan sequencer.
package mux_ctrl_pkg;
    localparam int unsigned MUX_CH = 8;
    localparam int unsigned MUX_AW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;
endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// Request/result and mux-side signals of the scan sequencer.
interface mux8_scan_ctrl_if;
    import mux_ctrl_pkg::*;

    logic              start;
    logic [MUX_CH-1:0] ch_mask;
    logic              mux_out;
    logic              mux_en_n;
    logic [MUX_AW-1:0] mux_addr;
    logic              busy;
    logic              done;
    logic [MUX_CH-1:0] sample;

    modport master (
        output start, ch_mask, mux_out,
        input  mux_en_n, mux_addr, busy, done, sample
    );

    modport slave (
        input  start, ch_mask, mux_out,
        output mux_en_n, mux_addr, busy, done, sample
    );
endinterface

// File: rtl/mux_next_ch.sv
// Priority encoder: next set mask bit above cur_i, or lowest set bit when first_i.
module mux_next_ch
    import mux_ctrl_pkg::*;
(
    input  logic [MUX_CH-1:0] mask_i,
    input  logic [MUX_AW-1:0] cur_i,
    input  logic              first_i,
    output logic [MUX_AW-1:0] idx_o,
    output logic              found_o
);
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < MUX_CH; i++) begin
            if (!found_o && mask_i[i] && (first_i || i > int'(cur_i))) begin
                idx_o   = MUX_AW'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scans masked channels of an 8:1 mux in ascending order and returns a byte snapshot.
module mux8_scan_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux8_scan_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MUX_AW-1:0] addr_q, addr_d;
    logic [MUX_CH-1:0] mask_q, mask_d;
    logic [MUX_CH-1:0] sample_q, sample_d;

    logic              capturing;
    logic [MUX_CH-1:0] enc_mask;
    logic [MUX_AW-1:0] nxt_idx;
    logic              nxt_found;

    // One encoder serves both the first pick (live ch_mask) and the advance (latched mask).
    assign capturing = (state_q == CAPTURE);
    assign enc_mask  = capturing ? mask_q : bus.ch_mask;

    mux_next_ch u_next (
        .mask_i  (enc_mask),
        .cur_i   (addr_q),
        .first_i (!capturing),
        .idx_o   (nxt_idx),
        .found_o (nxt_found)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    mask_d   = bus.ch_mask;
                    sample_d = '0;
                    if (nxt_found) begin
                        addr_d  = nxt_idx;
                        cnt_d   = SETTLE_LOAD;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                sample_d[addr_q] = bus.mux_out;
                if (nxt_found) begin
                    addr_d  = nxt_idx;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
        end
    end

    assign bus.busy     = (state_q == SETTLE) || (state_q == CAPTURE);
    assign bus.mux_en_n = !bus.busy;
    assign bus.done     = (state_q == DONE);
    assign bus.mux_addr = addr_q;
    assign bus.sample   = sample_q;
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: SETTLE_CYCLES=2 and =0 builds against a schedule-based model.
module tb_mux8_scan_ctrl;
    import mux_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] mask;
    logic [7:0] in_a, in_b;

    always #5 clk = ~clk;

    mux8_scan_ctrl_if ifa ();
    mux8_scan_ctrl_if ifb ();

    assign ifa.start   = start;
    assign ifa.ch_mask = mask;
    assign ifb.start   = start;
    assign ifb.ch_mask = mask;
    assign ifa.mux_out = ifa.mux_en_n ? 1'b0 : in_a[ifa.mux_addr];
    assign ifb.mux_out = ifb.mux_en_n ? 1'b0 : in_b[ifb.mux_addr];

    mux8_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux8_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    // Model: an accepted start at edge E puts cycle k=1 after E; channel j occupies
    // cycles j*P+1..(j+1)*P (last one is capture), done at k=N*P+1.
    bit         m_act [2];
    int         m_k   [2];
    int         m_n   [2];
    int         m_ch  [2][8];
    logic [7:0] m_smp [2];
    logic [2:0] m_addr[2];
    logic [7:0] mi;
    bit         bz;

    function automatic int per(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic m_busy(input int d);
        return m_act[d] && m_k[d] >= 1 && m_k[d] <= m_n[d] * per(d);
    endfunction

    function automatic logic m_done(input int d);
        return m_act[d] && m_k[d] == m_n[d] * per(d) + 1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            mi = (d == 0) ? in_a : in_b;
            if (rst) begin
                m_act[d] = 1'b0; m_k[d] = 0; m_n[d] = 0; m_smp[d] = '0; m_addr[d] = '0;
            end else begin
                bz = m_busy(d);
                if (bz && (m_k[d] % per(d)) == 0)
                    m_smp[d][m_ch[d][(m_k[d]-1)/per(d)]] = mi[m_ch[d][(m_k[d]-1)/per(d)]];
                if (m_act[d]) begin
                    m_k[d]++;
                    if (m_k[d] > m_n[d] * per(d) + 1) m_act[d] = 1'b0;
                end
                if (start && !bz) begin
                    m_n[d] = 0;
                    for (int i = 0; i < 8; i++)
                        if (mask[i]) begin m_ch[d][m_n[d]] = i; m_n[d]++; end
                    m_k[d] = 1; m_act[d] = 1'b1; m_smp[d] = '0;
                end
                if (m_busy(d)) m_addr[d] = 3'(m_ch[d][(m_k[d]-1)/per(d)]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic en_n, input logic [2:0] addr,
                           input logic bsy, input logic dn, input logic [7:0] smp);
        chk($sformatf("d%0d.mux_en_n", d), 32'(en_n), 32'(!m_busy(d)));
        chk($sformatf("d%0d.mux_addr", d), 32'(addr), 32'(m_addr[d]));
        chk($sformatf("d%0d.busy", d),     32'(bsy),  32'(m_busy(d)));
        chk($sformatf("d%0d.done", d),     32'(dn),   32'(m_done(d)));
        chk($sformatf("d%0d.sample", d),   32'(smp),  32'(m_smp[d]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut(0, ifa.mux_en_n, ifa.mux_addr, ifa.busy, ifa.done, ifa.sample);
            cmp_dut(1, ifb.mux_en_n, ifb.mux_addr, ifb.busy, ifb.done, ifb.sample);
        end
    end

    // Launch one scan; report done cycle and enable-low cycle count per DUT.
    task automatic scan(input logic [7:0] mk, input logic [7:0] ia, input logic [7:0] ib,
                        input int poke_c, input logic [7:0] poke_mask,
                        output int da, output int db, output int lowa, output int lowb);
        @(negedge clk);
        mask = mk; in_a = ia; in_b = ib; start = 1'b1;
        da = -1; db = -1; lowa = 0; lowb = 0;
        for (int c = 1; c <= 100 && (da < 0 || db < 0); c++) begin
            @(negedge clk);
            start = (c == poke_c);
            if (c == poke_c) mask = poke_mask;
            if (!ifa.mux_en_n) lowa++;
            if (!ifb.mux_en_n) lowb++;
            if (ifa.done && da < 0) da = c;
            if (ifb.done && db < 0) db = c;
        end
        start = 1'b0;
    endtask

    int da, db, la, lb, dones;

    initial begin
        rst = 1'b1; start = 1'b0; mask = '0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.en_n_a", 32'(ifa.mux_en_n), 32'(1));
        chk("rst.addr_a", 32'(ifa.mux_addr), 32'(0));
        chk("rst.busy_a", 32'(ifa.busy), 32'(0));
        chk("rst.done_a", 32'(ifa.done), 32'(0));
        chk("rst.sample_a", 32'(ifa.sample), 32'(0));
        chk("rst.sample_b", 32'(ifb.sample), 32'(0));
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        scan(8'hFF, 8'hA5, 8'hA5, 0, 8'h00, da, db, la, lb);
        chk("full.done_a", 32'(da), 32'(33));
        chk("full.low_a", 32'(la), 32'(32));
        chk("full.sample_a", 32'(ifa.sample), 32'hA5);
        chk("full.done_b", 32'(db), 32'(17));
        chk("full.sample_b", 32'(ifb.sample), 32'hA5);

        scan(8'h81, 8'hFF, 8'hFF, 0, 8'h00, da, db, la, lb);
        chk("sparse.done_a", 32'(da), 32'(9));
        chk("sparse.low_a", 32'(la), 32'(8));
        chk("sparse.sample_a", 32'(ifa.sample), 32'h81);
        chk("sparse.done_b", 32'(db), 32'(5));

        scan(8'h00, 8'hFF, 8'hFF, 0, 8'h00, da, db, la, lb);
        chk("zero.done_a", 32'(da), 32'(1));
        chk("zero.low_a", 32'(la), 32'(0));
        chk("zero.sample_a", 32'(ifa.sample), 32'h00);

        scan(8'hFF, 8'h3C, 8'h3C, 5, 8'h01, da, db, la, lb);
        chk("busy_start.done_a", 32'(da), 32'(33));
        chk("busy_start.sample_a", 32'(ifa.sample), 32'h3C);

        // Still in dut_a's DONE cycle: issue a back-to-back scan.
        mask = 8'h02; in_a = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.busy_a", 32'(ifa.busy), 32'(1));
        chk("b2b.done_a", 32'(ifa.done), 32'(0));
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("b2b.done5_a", 32'(ifa.done), 32'(1));
        chk("b2b.sample_a", 32'(ifa.sample), 32'h02);

        @(negedge clk);
        mask = 8'hFF; in_a = 8'hFF; in_b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !(ifa.mux_addr == 3'd3 && !ifa.mux_en_n); c++) @(negedge clk);
        chk("midrst.reached_ch3", 32'(ifa.mux_addr), 32'(3));
        chk("midrst.partial_a", 32'(ifa.sample), 32'h07);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.en_n_a", 32'(ifa.mux_en_n), 32'(1));
        chk("midrst.busy_a", 32'(ifa.busy), 32'(0));
        chk("midrst.sample_a", 32'(ifa.sample), 32'h00);
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ifa.done || ifb.done) dones++;
        end
        chk("midrst.no_done", 32'(dones), 32'(0));

        scan(8'h0F, 8'h0A, 8'h0A, 0, 8'h00, da, db, la, lb);
        chk("s0.done_b", 32'(db), 32'(9));
        chk("s0.low_b", 32'(lb), 32'(8));
        chk("s0.sample_b", 32'(ifb.sample), 32'h0A);
        chk("s0.done_a", 32'(da), 32'(17));

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 5) == 0);
            mask  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 15) == 0) in_a = 8'($urandom);
            if ($urandom_range(0, 15) == 0) in_b = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
